// File: rtl/vec_mem_bank.sv
// Byte-addressed, little-endian burst memory bank with per-byte write strobes.
// Latency: first read beat RD_LAT cycles after accept, then one beat per cycle; done pulses one cycle after the last beat.
// Backpressure: req_ready only in IDLE; wr_valid gaps stall a write burst; read beats cannot be stalled.
//
// Ports:
//   clk, rst            clock and asynchronous active-low reset
//   req_*               request channel (rw, byte address, beats-1), valid/ready
//   wr_*                write beat channel, wr_ready held high for the whole write burst
//   rd_*                read beat channel, no backpressure, rd_data zero when idle
//   done, err           one-cycle completion pulse; err qualifies done
module vec_mem_bank #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int RD_LAT      = 1,
  parameter int MAX_BURST   = 8,
  localparam int BYTES      = DATA_W / 8,
  localparam int LEN_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [31:0]       req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BYTES-1:0]  wr_strb,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              err
);

  localparam int WORDS = DEPTH_BYTES / BYTES;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF   = $clog2(BYTES);
  localparam int LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {IDLE, RWAIT, RBEAT, WBEAT, DONE} state_t;

  state_t            state, state_n;
  logic              live;       // low until the first edge after reset release
  logic              accept;
  logic              req_err;
  logic [33:0]       end_b;      // one past the last byte, wide enough to never wrap
  logic [AW-1:0]     ptr_q;      // word index of the current beat
  logic [AW-1:0]     fetch_idx;  // word index to be presented on rd_data next cycle
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [LAT_W-1:0]  lat_q;
  logic              err_q;
  logic [DATA_W-1:0] mem [WORDS];

  assign end_b   = 34'(req_addr) + 34'(req_len) * 34'(BYTES) + 34'(BYTES);
  assign req_err = ((req_addr & 32'(BYTES - 1)) != 32'd0) || (end_b > 34'(DEPTH_BYTES));
  assign accept  = req_valid && live && (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = live;
        if (accept) begin
          if (req_err)     state_n = DONE;
          else if (req_rw) state_n = WBEAT;
          else             state_n = (RD_LAT > 1) ? RWAIT : RBEAT;
        end
      end
      RWAIT: begin
        // RWAIT covers RD_LAT-1 cycles so the first beat lands RD_LAT after accept
        if (lat_q == LAT_W'(RD_LAT - 2)) state_n = RBEAT;
      end
      RBEAT: begin
        rd_valid = 1'b1;
        rd_last  = (beat_q == len_q);
        if (beat_q == len_q) state_n = DONE;
      end
      WBEAT: begin
        wr_ready = 1'b1;
        if (wr_valid && (beat_q == len_q)) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // rd_data is registered: fetch the word the next cycle's beat will show
  always_comb begin
    case (state)
      IDLE:    fetch_idx = req_addr[OFF +: AW];
      RBEAT:   fetch_idx = ptr_q + AW'(1);
      default: fetch_idx = ptr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live    <= 1'b0;
      ptr_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
      rd_data <= '0;
    end else begin
      live    <= 1'b1;
      rd_data <= (state_n == RBEAT) ? mem[fetch_idx] : '0;
      if (accept) begin
        ptr_q  <= req_addr[OFF +: AW];
        len_q  <= req_len;
        beat_q <= '0;
        lat_q  <= '0;
        err_q  <= req_err;
      end else if (state == RWAIT) begin
        lat_q <= lat_q + LAT_W'(1);
      end else if ((state == RBEAT) || ((state == WBEAT) && wr_valid)) begin
        ptr_q  <= ptr_q + AW'(1);
        beat_q <= beat_q + LEN_W'(1);
      end
    end
  end

  // Storage is deliberately not reset so data survives an aborted burst
  always_ff @(posedge clk) begin
    if ((state == WBEAT) && wr_valid) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_strb[b]) mem[ptr_q][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_bank.sv
// Randomized and directed stimulus against a byte-array reference model; a scoreboard
// monitor pops expected read beats and done pulses (with their cycle) as they appear.
// A second instance (64-bit beats, single-cycle read latency) covers the parameter sweep.
module tb_vec_mem_bank;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int NB    = 4;

  typedef struct packed {logic [31:0] d; logic last; int cyc;} rd_exp_t;
  typedef struct packed {logic e; int cyc;} done_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_rw;
  logic [31:0] req_addr;
  logic [2:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid, rd_last, done, err;
  logic [31:0] rd_data;

  logic        b_req_valid, b_req_ready, b_req_rw;
  logic [31:0] b_req_addr;
  logic [2:0]  b_req_len;
  logic        b_wr_valid, b_wr_ready;
  logic [63:0] b_wr_data;
  logic [7:0]  b_wr_strb;
  logic        b_rd_valid, b_rd_last, b_done, b_err;
  logic [63:0] b_rd_data;

  vec_mem_bank #(.DATA_W(32), .DEPTH_BYTES(DEPTH), .RD_LAT(LAT), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err)
  );

  vec_mem_bank #(.DATA_W(64), .DEPTH_BYTES(DEPTH), .RD_LAT(1), .MAX_BURST(8)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_rw(b_req_rw),
    .req_addr(b_req_addr), .req_len(b_req_len),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data), .wr_strb(b_wr_strb),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_last(b_rd_last),
    .done(b_done), .err(b_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  mdl [DEPTH];
  logic [31:0] beat_d [8];
  logic [3:0]  beat_s [8];
  rd_exp_t     exp_rd[$];
  done_exp_t   exp_done[$];
  rd_exp_t     mre;
  done_exp_t   mde;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Scoreboard monitor: every cycle either an expected event matches or the idle values hold.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_rd.size() == 0) fail("rd_unexpected");
      else begin
        mre = exp_rd.pop_front();
        chk("rd_data", 64'(rd_data), 64'(mre.d));
        chk("rd_last", 64'(rd_last), 64'(mre.last));
        chk("rd_cycle", 64'(cyc), 64'(mre.cyc));
      end
    end else begin
      chk("rd_data_idle", 64'(rd_data), 64'd0);
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) fail("done_unexpected");
      else begin
        mde = exp_done.pop_front();
        chk("err", 64'(err), 64'(mde.e));
        chk("done_cycle", 64'(cyc), 64'(mde.cyc));
      end
    end else begin
      chk("err_idle", 64'(err), 64'd0);
    end
  end

  task automatic fill_rand(input logic full);
    for (int i = 0; i < 8; i++) begin
      beat_d[i] = $urandom;
      beat_s[i] = full ? 4'hF : 4'($urandom_range(0, 15));
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_rd.size() != 0 || exp_done.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (t >= 100) begin
      fail("response_timeout");
      exp_rd.delete();
      exp_done.delete();
    end
  endtask

  task automatic reset_mid();
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_last", 64'(rd_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    wr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rdy_before_edge", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 chk("rdy_after_edge", 64'(req_ready), 64'd1);
  endtask

  // One transaction on the 32-bit instance. Beat data/strobes come from beat_d/beat_s.
  task automatic do_req(input logic rw, input int addr, input int len,
                        input int gap_at, input int gap_n, input int abort_at);
    int t, a, h;
    logic e;
    logic [31:0] d;
    e = (addr % NB != 0) || (addr + (len + 1) * NB > DEPTH);
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_addr = 32'(addr); req_len = 3'(len);
    wr_valid = 1'b1; wr_data = $urandom; wr_strb = 4'hF;   // stray beats must be ignored
    t = 0;
    while (req_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      fail("req_accept_timeout");
      req_valid = 1'b0; wr_valid = 1'b0;
      return;
    end
    a = cyc;
    if (e) exp_done.push_back('{1'b1, a + 1});
    else if (!rw) begin
      for (int i = 0; i <= len; i++) begin
        for (int b = 0; b < NB; b++) d[8*b +: 8] = mdl[addr + i*NB + b];
        exp_rd.push_back('{d, (i == len), a + LAT + i});
      end
      exp_done.push_back('{1'b0, a + LAT + len + 1});
    end
    @(negedge clk);
    req_valid = 1'b0; wr_valid = 1'b0;
    if (rw && !e) begin
      for (int i = 0; i <= len; i++) begin
        if (i == abort_at) begin
          reset_mid();
          return;
        end
        if (i == gap_at) repeat (gap_n) @(negedge clk);
        wr_valid = 1'b1; wr_data = beat_d[i]; wr_strb = beat_s[i];
        t = 0;
        while (wr_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
          fail("wr_ready_timeout");
          wr_valid = 1'b0;
          return;
        end
        h = cyc;
        for (int b = 0; b < NB; b++)
          if (beat_s[i][b]) mdl[addr + i*NB + b] = beat_d[i][8*b +: 8];
        if (i == len) exp_done.push_back('{1'b0, h + 1});
        @(negedge clk);
        wr_valid = 1'b0;
      end
    end
    wait_idle();
  endtask

  // Single-beat transaction on the 64-bit, single-cycle-latency instance.
  task automatic b_txn(input logic rw, input logic [31:0] addr, input logic [63:0] wd,
                       input logic exp_err, input logic [63:0] exp_d);
    int t, a, h, rdc, dc;
    logic [63:0] rdd;
    logic rl, e;
    rdc = -1; dc = -1; rdd = '0; rl = 1'b0; e = 1'b0; h = 0;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_rw = rw; b_req_addr = addr; b_req_len = 3'd0;
    t = 0;
    while (b_req_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin fail("b_accept_timeout"); b_req_valid = 1'b0; return; end
    a = cyc;
    @(negedge clk);
    b_req_valid = 1'b0;
    if (rw && !exp_err) begin
      b_wr_valid = 1'b1; b_wr_data = wd; b_wr_strb = 8'hFF;
      t = 0;
      while (b_wr_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      h = cyc;
      @(negedge clk);
      b_wr_valid = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      if (b_rd_valid === 1'b1 && rdc < 0) begin rdc = cyc; rdd = b_rd_data; rl = b_rd_last; end
      if (b_done === 1'b1) begin dc = cyc; e = b_err; break; end
      @(negedge clk);
    end
    if (dc < 0) begin fail("b_done_timeout"); return; end
    chk("b_err", 64'(e), 64'(exp_err));
    if (exp_err) begin
      chk("b_err_no_rd", 64'(rdc), 64'(-1));
      chk("b_err_done_lat", 64'(dc - a), 64'd1);
    end else if (!rw) begin
      chk("b_rd_lat", 64'(rdc - a), 64'd1);
      chk("b_rd_last", 64'(rl), 64'd1);
      chk("b_rd_data", rdd, exp_d);
      chk("b_rd_done_lat", 64'(dc - a), 64'd2);
    end else begin
      chk("b_wr_done_lat", 64'(dc - h), 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
    b_req_valid = 1'b0; b_req_rw = 1'b0; b_req_addr = '0; b_req_len = '0;
    b_wr_valid = 1'b0; b_wr_data = '0; b_wr_strb = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_wr_ready", 64'(wr_ready), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst = 1'b1;
    #1 chk("release_rdy_pre", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 chk("release_rdy_post", 64'(req_ready), 64'd1);

    // Give every byte a known value so any later read has a defined expectation.
    for (int w = 0; w < DEPTH; w += 32) begin
      fill_rand(1'b1);
      do_req(1'b1, w, 7, -1, 0, -1);
    end

    // Basic two-beat write then read back.
    beat_d[0] = 32'h11223344; beat_d[1] = 32'h55667788; beat_s[0] = 4'hF; beat_s[1] = 4'hF;
    do_req(1'b1, 'h10, 1, -1, 0, -1);
    do_req(1'b0, 'h10, 1, -1, 0, -1);

    // Partial strobe merges with earlier contents.
    beat_d[0] = 32'hAABBCCDD; beat_s[0] = 4'hF;
    do_req(1'b1, 'h20, 0, -1, 0, -1);
    beat_d[0] = 32'h00000000; beat_s[0] = 4'h5;
    do_req(1'b1, 'h20, 0, -1, 0, -1);
    do_req(1'b0, 'h20, 0, -1, 0, -1);

    // Misaligned, overrun, and exactly-at-end bursts.
    do_req(1'b0, 'h02, 0, -1, 0, -1);
    fill_rand(1'b1);
    do_req(1'b1, 'h3F8, 2, -1, 0, -1);
    do_req(1'b0, 'h3F8, 1, -1, 0, -1);
    do_req(1'b0, 'h3FC, 1, -1, 0, -1);

    // Write burst with a three-cycle wr_valid gap before the third beat.
    fill_rand(1'b1);
    do_req(1'b1, 'h80, 3, 2, 3, -1);
    do_req(1'b0, 'h80, 3, -1, 0, -1);

    // Reset after two beats of a four-beat write: first two stored, rest untouched.
    fill_rand(1'b1);
    do_req(1'b1, 'h40, 3, -1, 0, 2);
    do_req(1'b0, 'h40, 3, -1, 0, -1);

    // Random traffic, including misaligned and overrunning requests.
    for (int n = 0; n < 60; n++) begin
      int rw, len, addr, ga;
      rw   = $urandom_range(0, 1);
      len  = $urandom_range(0, 7);
      addr = $urandom_range(0, 255) * 4;
      if ($urandom_range(0, 7) == 0) addr += $urandom_range(1, 3);
      ga   = $urandom_range(0, len);
      fill_rand(1'b0);
      do_req(rw[0], addr, len, ga, $urandom_range(0, 2), -1);
    end

    // 64-bit beats, single-cycle read latency.
    b_txn(1'b1, 32'h8, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0);
    b_txn(1'b0, 32'h8, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF);
    b_txn(1'b0, 32'h4, 64'd0, 1'b1, 64'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
